sample_fifo_mem: RTL and testbench

Parametrised synchronous sample FIFO. It replaces the raw addressed sample memory in the NEO datapath with a self-addressing circular buffer. Upstream (ADC/sample front end) pushes signed samples with a valid/ready handshake; the NEO window logic pops them in order from a registered output stage. The block adds occupancy tracking, full/empty/almost-full flags, a synchronous flush and a sticky overflow flag.

---
 rtl/neo_pkg.sv | 13 +
 rtl/sample_fifo_ram.sv | 46 ++++
 rtl/sample_fifo_mem.sv | 120 ++++++++++++
 tb/tb_sample_fifo_mem.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/neo_pkg.sv
// rtl/neo_pkg.sv - shared sample types and FIFO sizing for the NEO datapath
package neo_pkg;

    localparam int SAMPLE_W   = 8;
    localparam int FIFO_DEPTH = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sample_fifo_ram.sv
// rtl/sample_fifo_ram.sv - M x N simple dual-port sample RAM with registered read
module sample_fifo_ram
    import neo_pkg::*;
#(
    parameter int N = SAMPLE_W,
    parameter int M = FIFO_DEPTH
) (
    input  logic                  Clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ptr_w(M)-1:0]   waddr,
    input  logic signed [N-1:0]   wdata,
    input  logic                  re,
    input  logic [ptr_w(M)-1:0]   raddr,
    output logic signed [N-1:0]   rdata
);

    logic signed [N-1:0] mem [M];
    logic signed [N-1:0] rdata_d;
    logic signed [N-1:0] rdata_q;

    // The array itself is never reset; only the read register is.
    always_ff @(posedge Clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sample_fifo_mem.sv
// rtl/sample_fifo_mem.sv - self-addressing sample FIFO with prefetched output stage
module sample_fifo_mem
    import neo_pkg::*;
#(
    parameter int N        = SAMPLE_W,
    parameter int M        = FIFO_DEPTH,
    parameter int AF_LEVEL = M - 2
) (
    input  logic                     Clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic signed [N-1:0]      wdata,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic signed [N-1:0]      rdata,
    output logic [$clog2(M):0]       count,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     overflow
);

    localparam int AW = ptr_w(M);
    localparam int CW = $clog2(M) + 1;

    logic [AW-1:0] wr_ptr_d, wr_ptr_q;
    logic [AW-1:0] rd_ptr_d, rd_ptr_q;
    logic [CW-1:0] count_d, count_q;
    logic          rd_valid_d, rd_valid_q;
    logic          overflow_d, overflow_q;

    logic [CW-1:0] mem_count;
    logic          push;
    logic          pop;
    logic          load;
    logic          ram_we;
    logic          ram_re;

    always_comb begin
        full        = (count_q == CW'(M));
        empty       = (count_q == '0);
        almost_full = (count_q >= CW'(AF_LEVEL));
        wr_ready    = !full;
    end

    // count includes the output stage, so the array holds count minus rd_valid.
    always_comb begin
        push      = wr_valid && !full;
        pop       = rd_valid_q && rd_ready;
        mem_count = count_q - CW'(rd_valid_q);
        load      = (mem_count != '0) && (!rd_valid_q || pop);

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_valid_d = rd_valid_q;
        overflow_d = overflow_q;
        ram_we     = 1'b0;
        ram_re     = 1'b0;

        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            rd_valid_d = 1'b0;
            overflow_d = 1'b0;
        end else begin
            ram_we     = push;
            ram_re     = load;
            overflow_d = overflow_q || (wr_valid && !wr_ready);
            count_d    = count_q + CW'(push) - CW'(pop);
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (load) begin
                rd_ptr_d   = rd_ptr_q + AW'(1);
                rd_valid_d = 1'b1;
            end else if (pop) begin
                rd_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            overflow_q <= overflow_d;
        end
    end

    sample_fifo_ram #(
        .N (N),
        .M (M)
    ) u_ram (
        .Clk   (Clk),
        .reset (reset),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata (wdata),
        .re    (ram_re),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    assign count    = count_q;
    assign rd_valid = rd_valid_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_sample_fifo_mem.sv
// tb/tb_sample_fifo_mem.sv - scoreboard bench for sample_fifo_mem
module tb_sample_fifo_mem;
    import neo_pkg::*;

    logic        Clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        wr_valid;
    logic        wr_ready;
    sample_t     wdata;
    logic        rd_valid;
    logic        rd_ready;
    sample_t     rdata;
    logic [4:0]  count;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        overflow;

    int      n_checks = 0;
    int      n_pass   = 0;
    sample_t exp_q[$];

    always #5 Clk = ~Clk;

    sample_fifo_mem #(.N(8), .M(16), .AF_LEVEL(14)) dut (
        .Clk         (Clk),
        .reset       (reset),
        .clear       (clear),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wdata       (wdata),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rdata       (rdata),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .overflow    (overflow)
    );

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Inputs apply at the next rising edge; returns 2ns after that edge.
    task automatic tick(input logic wv, input int wd, input logic rr,
                        input logic clr, input logic acc);
        wr_valid = wv;
        wdata    = sample_t'(wd);
        rd_ready = rr;
        clear    = clr;
        if (clr) exp_q.delete();
        else if (wv && acc) exp_q.push_back(sample_t'(wd));
        @(posedge Clk);
        #2;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || empty !== 1'b1) && n < 60) begin
            tick(1'b0, 0, 1'b1, 1'b0, 1'b0);
            n++;
        end
        check("drain_left", exp_q.size(), 0);
        check("drain_empty", empty, 1);
    endtask

    always @(negedge Clk) begin
        sample_t e;
        if (reset === 1'b1 && rd_valid === 1'b1 && rd_ready === 1'b1 && clear === 1'b0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_pop: got rdata %0d, expected no pop", rdata);
            end else begin
                e = exp_q.pop_front();
                check("pop_data", rdata, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; clear = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wdata = '0;
        repeat (2) @(posedge Clk);
        #2;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_af", almost_full, 0);
        check("rst_wr_ready", wr_ready, 1);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_overflow", overflow, 0);
        reset = 1'b1;

        // single sample latency
        tick(1, -3, 0, 0, 1);
        check("t1_count", count, 1);
        check("t1_no_bypass", rd_valid, 0);
        tick(0, 0, 0, 0, 0);
        check("t1_rd_valid", rd_valid, 1);
        check("t1_rdata", rdata, -3);
        check("t1_count_held", count, 1);
        tick(0, 0, 1, 0, 0);
        check("t1_empty", empty, 1);
        check("t1_count_zero", count, 0);
        check("t1_rd_valid_low", rd_valid, 0);

        // fill to full, overflow, drain
        for (int i = 1; i <= 16; i++) begin
            tick(1, i, 0, 0, 1);
            check("t2_count", count, i);
            check("t2_af", almost_full, (i >= 14) ? 1 : 0);
        end
        check("t2_full", full, 1);
        check("t2_wr_ready", wr_ready, 0);
        tick(1, 17, 0, 0, 0);
        check("t2_overflow", overflow, 1);
        check("t2_count_16", count, 16);
        drain();
        tick(0, 0, 0, 1, 0);
        check("t2_clear_ovf", overflow, 0);

        // streaming with pointer wrap
        tick(1, -20, 1, 0, 1);
        for (int v = -19; v <= 19; v++) begin
            tick(1, v, 1, 0, 1);
            check("t3_count", count, 2);
            check("t3_rd_valid", rd_valid, 1);
        end
        drain();

        // full with simultaneous write and pop
        for (int i = 0; i < 16; i++) tick(1, 100 + i, 0, 0, 1);
        check("t4_full", full, 1);
        tick(1, 99, 1, 0, 0);
        check("t4_overflow", overflow, 1);
        check("t4_count", count, 15);
        check("t4_wr_ready", wr_ready, 1);
        tick(1, 50, 0, 0, 1);
        check("t4_count_16", count, 16);
        drain();
        tick(0, 0, 0, 1, 0);

        // clear with concurrent push
        for (int i = 0; i < 5; i++) tick(1, 10 + i, 0, 0, 1);
        tick(1, 88, 0, 1, 0);
        check("t5_count", count, 0);
        check("t5_rd_valid", rd_valid, 0);
        check("t5_overflow", overflow, 0);
        check("t5_empty", empty, 1);
        check("t5_rdata_held", rdata, 10);
        tick(1, 7, 0, 0, 1);
        tick(0, 0, 0, 0, 0);
        check("t5_rdata7", rdata, 7);
        tick(0, 0, 1, 0, 0);
        check("t5_empty_after", empty, 1);

        // asynchronous reset mid-stream
        for (int i = 0; i < 8; i++) tick(1, 30 + i, 0, 0, 1);
        check("t6_count", count, 8);
        #3;
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("t6_count_rst", count, 0);
        check("t6_rd_valid_rst", rd_valid, 0);
        check("t6_rdata_rst", rdata, 0);
        check("t6_empty_rst", empty, 1);
        check("t6_wr_ready_rst", wr_ready, 1);
        check("t6_full_rst", full, 0);
        @(posedge Clk);
        #2;
        reset = 1'b1;
        tick(1, -128, 0, 0, 1);
        tick(0, 0, 0, 0, 0);
        check("t6_rdata", rdata, -128);
        tick(0, 0, 1, 0, 0);
        check("t6_empty_after", empty, 1);
        check("t6_queue_left", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
